// File: rtl/dot_tree_sched.sv
// dot_tree_sched
//   Round-robin scheduler that shares one pipelined N-input adder tree among
//   R requesters. A requester is granted the tree for a whole packet. Each
//   beat's tree sum is accumulated, and one result per packet is returned,
//   tagged with the id of the requester that sent it.
//
// Ports
//   clock, resetn    clock; asynchronous active-low reset
//   req_valid[R]     beat valid, one bit per requester
//   req_last[R]      marks the last beat of a packet, one bit per requester
//   req_data[R*N*W]  beat payloads; requester i uses slice [i*N*W +: N*W]
//   req_ready[R]     a beat is accepted when valid & ready (combinational)
//   tree_in[N*W]     registered operand vector driven to the adder tree
//   tree_in_valid    tree_in holds a live beat this cycle
//   tree_out[W]      tree sum, valid exactly LAT cycles after its tree_in
//   res_valid        one-cycle result pulse (there is no backpressure)
//   res_id[IDW]      requester that owns the result
//   res_data[AW]     packet sum, wrapping mod 2^AW
module dot_tree_sched #(
  parameter int N   = 8,
  parameter int W   = 16,
  parameter int R   = 4,
  parameter int LAT = 3,
  parameter int AW  = 32,
  parameter int IDW = 2
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [R-1:0]       req_valid,
  input  logic [R-1:0]       req_last,
  input  logic [R*N*W-1:0]   req_data,
  output logic [R-1:0]       req_ready,
  output logic [N*W-1:0]     tree_in,
  output logic               tree_in_valid,
  input  logic [W-1:0]       tree_out,
  output logic               res_valid,
  output logic [IDW-1:0]     res_id,
  output logic [AW-1:0]      res_data
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t         state, state_next;
  logic [IDW-1:0] rr, rr_next;
  logic [IDW-1:0] owner, owner_next;

  // Round-robin search result (valid only while IDLE).
  logic [IDW-1:0] winner;
  logic           found;

  // Grant and the beat selected through it.
  logic [R-1:0]   grant;
  logic           issue;
  logic [IDW-1:0] sel_id;
  logic [N*W-1:0] sel_data;
  logic           sel_last;

  // Tag pipe: stage k describes the beat that entered the tree k cycles ago.
  logic [LAT:0]   tag_valid;
  logic [LAT:0]   tag_last;
  logic [IDW-1:0] tag_id [LAT+1];

  logic [AW-1:0]  acc;
  logic           first;
  logic [AW-1:0]  tree_ext;
  logic [AW-1:0]  acc_next;

  logic [N*W-1:0] slice [R];

  for (genvar g = 0; g < R; g++) begin : g_slice
    assign slice[g] = req_data[g*N*W +: N*W];
  end

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    if (int'(id) == R - 1) return '0;
    return id + 1'b1;
  endfunction

  // First valid requester at or after rr, wrapping. With a single requester
  // the grant does not depend on valid at all.
  always_comb begin
    logic [R-1:0]   rot;
    logic [IDW-1:0] pos;
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    winner = '0;
    found  = 1'b0;
    rot    = '0;
    pos    = '0;
    for (int i = 0; i < R; i++) begin
      pos = IDW'((int'(rr) + i) % R);
      rot = req_valid >> pos;
      if (!found && rot[0]) begin
        winner = pos;
        found  = 1'b1;
      end
    end
    if (R == 1) begin
      winner = '0;
      found  = 1'b1;
    end
  end

  // Arbiter next state, grant and beat selection.
  always_comb begin
    state_next = state;
    rr_next    = rr;
    owner_next = owner;
    grant      = '0;
    sel_data   = '0;
    sel_last   = 1'b0;
    sel_id     = (state == LOCKED) ? owner : winner;

    case (state)
      IDLE:    if (found) grant = R'(1) << winner;
      LOCKED:  grant = R'(1) << owner;
      default: grant = '0;
    endcase

    // Nothing is granted while reset is held.
    req_ready = grant & {R{resetn}};
    issue     = |(req_valid & req_ready);

    for (int i = 0; i < R; i++) begin
      if (grant[i]) begin
        sel_data = slice[i];
        sel_last = req_last[i];
      end
    end

    if (issue) begin
      if (sel_last) begin
        state_next = IDLE;
        rr_next    = next_id(sel_id);
      end else if (state == IDLE) begin
        state_next = LOCKED;
        owner_next = winner;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      rr    <= '0;
      owner <= '0;
    end else begin
      state <= state_next;
      rr    <= rr_next;
      owner <= owner_next;
    end
  end

  // Sign-extend the tree sum; a fresh packet starts from zero instead of acc.
  assign tree_ext = AW'(signed'(tree_out));
  assign acc_next = (first ? '0 : acc) + tree_ext;

  // NOTE: the tag pipe is a small register array that must be reset, because
  // its valid bits decide whether a stale tree_out is accumulated after reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tree_in       <= '0;
      tree_in_valid <= 1'b0;
      tag_valid     <= '0;
      tag_last      <= '0;
      for (int k = 0; k <= LAT; k++) tag_id[k] <= '0;
      acc           <= '0;
      first         <= 1'b1;
      res_valid     <= 1'b0;
      res_id        <= '0;
      res_data      <= '0;
    end else begin
      // tree_in holds its value on idle cycles; only the valid bit drops.
      if (issue) tree_in <= sel_data;
      tree_in_valid <= issue;

      tag_valid <= {tag_valid[LAT-1:0], issue};
      tag_last  <= {tag_last[LAT-1:0], sel_last};
      tag_id[0] <= sel_id;
      for (int k = 1; k <= LAT; k++) tag_id[k] <= tag_id[k-1];

      // Stage LAT lines up with tree_out for the same beat.
      if (tag_valid[LAT]) begin
        acc   <= acc_next;
        first <= tag_last[LAT];
      end

      res_valid <= tag_valid[LAT] & tag_last[LAT];
      if (tag_valid[LAT] && tag_last[LAT]) begin
        res_data <= acc_next;
        res_id   <= tag_id[LAT];
      end
    end
  end

endmodule

// File: tb/tb_dot_tree_sched.sv
// tb_dot_tree_sched
//   Self-checking bench for dot_tree_sched. A behavioural adder tree with LAT
//   cycles of latency sits on the tree port. Per-requester beat queues feed the
//   request ports. A monitor pushes the expected {id, sum, cycle} when a last
//   beat is accepted, and pops and compares when res_valid fires. A second
//   instance (R=1, W=AW=8) covers the single-requester and narrow-wrap cases.
module tb_dot_tree_sched;

  localparam int N   = 8;
  localparam int W   = 16;
  localparam int R   = 4;
  localparam int LAT = 3;
  localparam int AW  = 32;
  localparam int IDW = 2;
  localparam int W8  = 8;

  logic               clock = 1'b0;
  logic               resetn;
  logic [R-1:0]       req_valid, req_last, req_ready;
  logic [R*N*W-1:0]   req_data;
  logic [N*W-1:0]     tree_in;
  logic               tree_in_valid;
  logic [W-1:0]       tree_out;
  logic               res_valid;
  logic [IDW-1:0]     res_id;
  logic [AW-1:0]      res_data;

  logic               v8_valid, v8_last, ready8;
  logic [N*W8-1:0]    v8_data, tree_in8;
  logic               tree_in_valid8;
  logic [W8-1:0]      tree_out8;
  logic               res_valid8;
  logic [0:0]         res_id8;
  logic [W8-1:0]      res_data8;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  dot_tree_sched #(.N(N), .W(W), .R(R), .LAT(LAT), .AW(AW), .IDW(IDW)) u_dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .tree_in(tree_in), .tree_in_valid(tree_in_valid), .tree_out(tree_out),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data)
  );

  dot_tree_sched #(.N(N), .W(W8), .R(1), .LAT(LAT), .AW(W8), .IDW(1)) u_dut8 (
    .clock(clock), .resetn(resetn),
    .req_valid(v8_valid), .req_last(v8_last), .req_data(v8_data),
    .req_ready(ready8),
    .tree_in(tree_in8), .tree_in_valid(tree_in_valid8), .tree_out(tree_out8),
    .res_valid(res_valid8), .res_id(res_id8), .res_data(res_data8)
  );

  initial forever #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [W-1:0] lane_sum(input logic [N*W-1:0] d);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + d[i*W +: W];
    return s;
  endfunction

  function automatic logic [W8-1:0] lane_sum8(input logic [N*W8-1:0] d);
    logic [W8-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + d[i*W8 +: W8];
    return s;
  endfunction

  function automatic logic [N*W-1:0] uniform(input logic [W-1:0] v);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = v;
    return r;
  endfunction

  function automatic logic [N*W-1:0] random_beat();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  // Behavioural adder trees: LAT register stages each.
  logic [W-1:0]  tpipe  [LAT];
  logic [W8-1:0] tpipe8 [LAT];
  always @(posedge clock) begin
    tpipe[0]  <= lane_sum(tree_in);
    tpipe8[0] <= lane_sum8(tree_in8);
    for (int k = 1; k < LAT; k++) begin
      tpipe[k]  <= tpipe[k-1];
      tpipe8[k] <= tpipe8[k-1];
    end
  end
  assign tree_out  = tpipe[LAT-1];
  assign tree_out8 = tpipe8[LAT-1];

  // Request sources.
  typedef struct { logic [N*W-1:0] data; logic last; } beat_t;
  beat_t        src_q [R][$];
  logic [R-1:0] pop_mask = '0;

  task automatic push_beat(input int r, input logic [N*W-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    src_q[r].push_back(b);
  endtask

  initial begin : driver
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < R; i++) begin
        if (pop_mask[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          req_valid[i]              = 1'b1;
          req_last[i]               = src_q[i][0].last;
          req_data[i*N*W +: N*W]    = src_q[i][0].data;
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
      pop_mask = '0;
    end
  end

  // Scoreboard.
  typedef struct { logic [IDW-1:0] id; logic [AW-1:0] data; int cyc; } exp_t;
  typedef struct { int id; int cyc; } gnt_t;
  exp_t          exp_q [$];
  gnt_t          gnt_q [$];
  logic [AW-1:0] acc_m [R];

  initial begin : monitor
    exp_t e;
    for (int i = 0; i < R; i++) acc_m[i] = '0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        exp_q.delete();
        for (int i = 0; i < R; i++) acc_m[i] = '0;
        pop_mask = '0;
      end else begin
        for (int i = 0; i < R; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            pop_mask[i] = 1'b1;
            gnt_q.push_back('{i, cyc});
            acc_m[i] = acc_m[i] + AW'(signed'(lane_sum(req_data[i*N*W +: N*W])));
            if (req_last[i]) begin
              exp_q.push_back('{IDW'(i), acc_m[i], cyc + 2 + LAT});
              acc_m[i] = '0;
            end
          end
        end
        if (res_valid) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL result_unexpected: got id=%0d data=%h at cyc %0d, expected no result",
                     res_id, res_data, cyc);
          end else begin
            e = exp_q.pop_front();
            if (res_id !== e.id || res_data !== e.data || cyc !== e.cyc) begin
              bad++;
              $display("FAIL result: got id=%0d data=%h cyc=%0d, expected id=%0d data=%h cyc=%0d",
                       res_id, res_data, cyc, e.id, e.data, e.cyc);
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    resetn    = 1'b0;
    req_valid = '0;
    req_last  = '0;
    v8_valid  = 1'b0;
    v8_last   = 1'b0;
    for (int i = 0; i < R; i++) src_q[i].delete();
    gnt_q.delete();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()
            + exp_q.size()) != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s_drain: timed out after %0d cycles, %0d results still owed",
               name, n, exp_q.size());
    end
  endtask

  task automatic wait_gnt(input int count, input int budget);
    int n;
    n = 0;
    while (gnt_q.size() < count && n < budget) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic wait_res(input int budget, output bit got);
    int n;
    n   = 0;
    got = 1'b0;
    while (n < budget) begin
      @(negedge clock);
      n++;
      if (res_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    v8_valid  = 1'b0;
    v8_last   = 1'b0;
    v8_data   = '0;
    #1;
    total++;
    if ({res_valid, res_id, res_data, tree_in_valid, tree_in, req_ready, ready8} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rv=%b id=%0d data=%h tv=%b tin=%h rdy=%b rdy8=%b, expected all 0",
               res_valid, res_id, res_data, tree_in_valid, tree_in, req_ready, ready8);
    end
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    total++;
    if (req_ready !== 4'b0000 || ready8 !== 1'b1) begin
      bad++;
      $display("FAIL idle_ready: got rdy=%b rdy8=%b, expected 0000 and 1", req_ready, ready8);
    end
  endtask

  task automatic test_single();
    bit got;
    gnt_q.delete();
    push_beat(0, uniform(16'd1), 1'b1);
    @(negedge clock);
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL single_ready: got %b, expected 0001", req_ready);
    end
    @(negedge clock);
    total++;
    if (tree_in_valid !== 1'b1 || tree_in !== uniform(16'd1)) begin
      bad++;
      $display("FAIL single_issue: got tv=%b tin=%h, expected 1 and %h",
               tree_in_valid, tree_in, uniform(16'd1));
    end
    wait_res(10, got);
    total++;
    if (!got || res_id !== 2'd0 || res_data !== 32'd8) begin
      bad++;
      $display("FAIL single_result: got seen=%0d id=%0d data=%h, expected id=0 data=8",
               got, res_id, res_data);
    end
    wait_idle("single", 20);
  endtask

  task automatic test_multi();
    bit got;
    gnt_q.delete();
    push_beat(2, uniform(16'd1), 1'b0);
    push_beat(2, uniform(16'd2), 1'b0);
    push_beat(2, uniform(16'd3), 1'b1);
    wait_res(15, got);
    total++;
    if (!got || res_id !== 2'd2 || res_data !== 32'd48) begin
      bad++;
      $display("FAIL multi_result: got seen=%0d id=%0d data=%h, expected id=2 data=48",
               got, res_id, res_data);
    end
    wait_idle("multi", 20);
    total++;
    if (gnt_q.size() != 3 || gnt_q[2].cyc - gnt_q[0].cyc != 2) begin
      bad++;
      $display("FAIL multi_contiguous: got %0d beats spanning %0d cycles, expected 3 beats spanning 2",
               gnt_q.size(), gnt_q.size() > 2 ? gnt_q[2].cyc - gnt_q[0].cyc : -1);
    end
  endtask

  task automatic test_lock();
    int exp_ids [5] = '{1, 1, 1, 3, 0};
    int errs;
    gnt_q.delete();
    push_beat(1, uniform(16'd4), 1'b0);
    push_beat(1, uniform(16'd5), 1'b0);
    push_beat(1, uniform(16'd6), 1'b1);
    wait_gnt(1, 10);
    push_beat(0, uniform(16'd7), 1'b1);
    push_beat(3, uniform(16'd9), 1'b1);
    @(negedge clock);
    total++;
    if (req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL lock_ready: got %b, expected 0010", req_ready);
    end
    wait_idle("lock", 30);
    errs = 0;
    for (int i = 0; i < 5; i++) if (i >= gnt_q.size() || gnt_q[i].id != exp_ids[i]) errs++;
    total++;
    if (errs != 0 || gnt_q.size() != 5) begin
      bad++;
      $display("FAIL lock_order: got %0d grants with %0d out of place, expected order 1,1,1,3,0",
               gnt_q.size(), errs);
    end
  endtask

  task automatic test_back_to_back();
    gnt_q.delete();
    push_beat(0, random_beat(), 1'b0);
    push_beat(0, random_beat(), 1'b1);
    push_beat(1, random_beat(), 1'b0);
    push_beat(1, random_beat(), 1'b1);
    wait_idle("b2b", 30);
    total++;
    if (gnt_q.size() != 4 || gnt_q[3].cyc - gnt_q[0].cyc != 3) begin
      bad++;
      $display("FAIL b2b_gapless: got %0d beats spanning %0d cycles, expected 4 beats spanning 3",
               gnt_q.size(), gnt_q.size() > 3 ? gnt_q[3].cyc - gnt_q[0].cyc : -1);
    end
  endtask

  task automatic test_signed();
    bit got;
    gnt_q.delete();
    push_beat(3, uniform(16'hFFFF), 1'b1);
    wait_res(15, got);
    total++;
    if (!got || res_id !== 2'd3 || res_data !== 32'hFFFF_FFF8) begin
      bad++;
      $display("FAIL signed_result: got seen=%0d id=%0d data=%h, expected id=3 data=fffffff8",
               got, res_id, res_data);
    end
    wait_idle("signed", 20);
  endtask

  task automatic test_fairness();
    int errs;
    do_reset();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < R; i++) push_beat(i, random_beat(), 1'b1);
    wait_idle("fair", 40);
    errs = 0;
    for (int k = 0; k < gnt_q.size(); k++) begin
      if (gnt_q[k].id != k % R) errs++;
      if (k > 0 && gnt_q[k].cyc != gnt_q[k-1].cyc + 1) errs++;
    end
    total++;
    if (errs != 0 || gnt_q.size() != 12) begin
      bad++;
      $display("FAIL fair_order: got %0d grants with %0d order/gap errors, expected 12 gapless 0,1,2,3,...",
               gnt_q.size(), errs);
    end
  endtask

  task automatic test_wrap8();
    int rdy_bad;
    int last_cyc;
    int n;
    rdy_bad  = 0;
    last_cyc = 0;
    for (int b = 0; b < 40; b++) begin
      @(posedge clock);
      #1;
      v8_valid = 1'b1;
      v8_last  = (b == 39);
      for (int i = 0; i < N; i++) v8_data[i*W8 +: W8] = 8'd1;
      @(negedge clock);
      if (ready8 !== 1'b1) rdy_bad++;
      last_cyc = cyc;
    end
    @(posedge clock);
    #1;
    v8_valid = 1'b0;
    v8_last  = 1'b0;
    total++;
    if (rdy_bad != 0) begin
      bad++;
      $display("FAIL wrap8_ready: got %0d cycles without ready, expected 0", rdy_bad);
    end
    n = 0;
    while (res_valid8 !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (res_valid8 !== 1'b1 || res_data8 !== 8'h40 || res_id8 !== 1'b0 || cyc != last_cyc + 2 + LAT) begin
      bad++;
      $display("FAIL wrap8_result: got rv=%b data=%h id=%0d cyc=%0d, expected 1 40 0 cyc=%0d",
               res_valid8, res_data8, res_id8, cyc, last_cyc + 2 + LAT);
    end
  endtask

  task automatic test_reset_midflight();
    int stray;
    bit got;
    gnt_q.delete();
    push_beat(2, uniform(16'd5), 1'b0);
    push_beat(2, uniform(16'd5), 1'b1);
    wait_gnt(2, 10);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b0;
    #1;
    total++;
    if ({res_valid, res_id, res_data, tree_in_valid, tree_in, req_ready} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got rv=%b id=%0d data=%h tv=%b tin=%h rdy=%b, expected all 0",
               res_valid, res_id, res_data, tree_in_valid, tree_in, req_ready);
    end
    for (int i = 0; i < R; i++) src_q[i].delete();
    req_valid = '0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    stray  = 0;
    repeat (10) begin
      @(negedge clock);
      if (res_valid === 1'b1) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL midreset_silent: got %0d result pulses, expected 0", stray);
    end
    push_beat(1, uniform(16'd2), 1'b1);
    wait_res(15, got);
    total++;
    if (!got || res_id !== 2'd1 || res_data !== 32'd16) begin
      bad++;
      $display("FAIL midreset_restart: got seen=%0d id=%0d data=%h, expected id=1 data=16",
               got, res_id, res_data);
    end
    wait_idle("restart", 20);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    test_reset();
    test_single();
    test_multi();
    test_lock();
    test_back_to_back();
    test_signed();
    test_fairness();
    test_wrap8();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dot_tree_sched.md
Name: dot_tree_sched

Overview:
- Round-robin scheduler sharing one pipelined N-input adder tree (latency LAT) among R requesters.
- Each requester sends a packet: one or more beats of N lanes of W bits, with the last beat flagged.
- The block grants the tree for a whole packet and tracks beats through the tree latency.
- It accumulates the per-beat tree sums and returns one AW-bit result, tagged with the requester id, per packet.

Parameters:
- N, 8, lanes per beat (tree width)
- W, 16, lane and tree-output width, two's complement
- R, 4, number of requesters
- LAT, 3, tree latency in cycles (log2 N)
- AW, 32, accumulator/result width (AW >= W)
- IDW, 2, requester id width (clog2 R)

Ports:
- clock  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  R  beat valid per requester
- req_last  in  R  last beat of packet per requester
- req_data  in  R*N*W  beat payload; requester i occupies slice [i*N*W +: N*W]
- req_ready  out  R  beat accepted when valid&ready
- tree_in  out  N*W  registered operand vector to adder tree
- tree_in_valid  out  1  tree_in holds a live beat
- tree_out  in  W  tree sum, valid exactly LAT cycles after the matching tree_in
- res_valid  out  1  one-cycle result pulse (no backpressure)
- res_id  out  IDW  requester owning the result
- res_data  out  AW  packet sum

Behaviour:
- Reset (async, resetn=0): state IDLE, rr pointer 0, tree_in 0, tree_in_valid 0, tag pipe cleared, acc 0, first=1, res_valid 0, res_id 0, res_data 0, req_ready 0.
- Arbiter states:
  - IDLE: winner = first requester with req_valid set, searching from rr pointer upward with wrap. Only the winner sees req_ready=1 (combinational, same cycle). On handshake: if req_last, stay IDLE and set rr=winner+1 mod R; else go to LOCKED with owner=winner.
  - LOCKED: req_ready = (1<<owner) only; other requesters are ignored. On an owner handshake with req_last: go to IDLE, rr=owner+1 mod R.
  - Owner with req_valid low in LOCKED: no issue that cycle, stay LOCKED (bubble).
- Issue: on a handshake at cycle t, tree_in <= the granted slice and tree_in_valid=1 at t+1. With no handshake, tree_in_valid=0 and tree_in holds its value.
- Tag pipe: a {valid,last,id} shift register of depth LAT+1, aligned so its head matches tree_out at cycle t+1+LAT.
- Accumulate at the head when head valid:
  - acc_next = (first ? 0 : acc) + sign-extend(tree_out) to AW bits, wrapping mod 2^AW.
  - acc <= acc_next.
  - If head last: res_valid=1, res_data=acc_next, res_id=head id at cycle t+2+LAT (registered), then first<=1. Otherwise first<=0.
- res_valid: low on every other cycle; res_data/res_id hold their last value.
- Back-to-back packets from different requesters: issue with no gap cycles; first-flag sequencing keeps accumulations separate.
- Throughput: one beat per cycle max; no stall path into the tree.
- Reset mid-packet: all in-flight beats are discarded and no result is emitted. The requester must restart the packet.
- R=1: arbiter degenerates; ready = valid-independent grant to requester 0 under the same IDLE/LOCKED rules.

Test Plan:
- Single beat: req0, all lanes 1, last=1 -> req_ready[0]=1 same cycle; tree_in_valid at t+1; res_valid at t+5, res_id=0, res_data=8.
- Multi-beat: req2 sends 3 beats, lanes = 1, 2, 3, last on beat 3, contiguous -> one result at beat3 time+5, res_id=2, res_data=48. No intermediate res_valid.
- Lock: req1 mid-packet while req0 and req3 are valid -> req_ready only to req1 until its last beat. Then the grant goes to req3 (rr=2 search), then req0.
- Fairness: all 4 requesters continuously send single-beat packets -> grants 0,1,2,3,0,...; results with ids in the same order, one per cycle, no gaps.
- Signed wrap: one beat with all lanes -1 (tree_out=0xFFF8) -> res_data=0xFFFFFFF8. AW=8 variant summing 40 beats of 8 -> res_data=0x40 (320 mod 256).
- Reset mid-flight: assert resetn=0 two cycles after a 2-beat packet's last handshake -> outputs zero immediately. After release, no res_valid; a new packet returns a correct result.
